// File: rtl/montgomery_mult_param.sv
// Parametrised radix-2 Montgomery multiplier: result = x*y*2^-WORD_WIDTH mod m.
// BITS_PER_CYCLE Montgomery iterations are chained combinationally per clock.
// Operands are latched at the accept edge. Input and output use valid/ready handshakes.
// Optional input checking is compiled in with the macro MONT_INPUT_CHECK_EN.
// That check covers an even modulus and operands that are not below m.
// Without the macro, err is constant 0.
module montgomery_mult_param #(
  parameter int WORD_WIDTH     = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WORD_WIDTH-1:0] m,
  input  logic [WORD_WIDTH-1:0] x,
  input  logic [WORD_WIDTH-1:0] y,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WORD_WIDTH-1:0] result,
  output logic                  err
);

  localparam int N  = WORD_WIDTH / BITS_PER_CYCLE;
  localparam int CW = $clog2(N + 1);
  localparam int AW = WORD_WIDTH + 2;

  typedef enum logic [1:0] {IDLE, LOOP, FINAL, HOLD} state_t;

  state_t                state_q;
  logic                  inReady_q;
  logic                  outValid_q;
  logic [WORD_WIDTH-1:0] result_q;
  logic                  err_q;
  logic                  bad_q;
  logic [AW-1:0]         acc_q;
  logic [CW-1:0]         cnt_q;
  logic [WORD_WIDTH-1:0] mReg_q;
  logic [WORD_WIDTH-1:0] xShift_q;
  logic [WORD_WIDTH-1:0] yReg_q;

  logic [AW-1:0]         acc_d;
  logic [WORD_WIDTH-1:0] result_d;
  logic [AW-1:0]         accWork;
  logic [AW-1:0]         sumWork;
  logic                  ui;
  logic [AW-1:0]         mExt;
  logic [AW-1:0]         yExt;
  logic                  inputBad;

  assign mExt = {2'b00, mReg_q};
  assign yExt = {2'b00, yReg_q};

`ifdef MONT_INPUT_CHECK_EN
  assign inputBad = ~m[0] | (x >= m) | (y >= m);
`else
  assign inputBad = 1'b0;
`endif

  assign in_ready  = inReady_q;
  assign out_valid = outValid_q;
  assign result    = result_q;
  assign err       = err_q;

  // Chain BITS_PER_CYCLE Montgomery steps on the accumulator; x is pre-shifted so bit j is the current bit
  always_comb begin
    accWork = acc_q;
    sumWork = '0;
    ui      = 1'b0;
    for (int j = 0; j < BITS_PER_CYCLE; j++) begin
      ui      = accWork[0] ^ (xShift_q[j] & yReg_q[0]);
      sumWork = accWork + (xShift_q[j] ? yExt : '0) + (ui ? mExt : '0);
      accWork = sumWork >> 1;
    end
    acc_d = accWork;
  end

  // Final conditional subtraction; the accumulator stays below 2m, so one subtraction is enough
  always_comb begin
    if (acc_q >= mExt) begin
      result_d = WORD_WIDTH'(acc_q - mExt);
    end else begin
      result_d = acc_q[WORD_WIDTH-1:0];
    end
  end

  // Control FSM with registered handshake outputs and operand latching
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      inReady_q  <= 1'b1;
      outValid_q <= 1'b0;
      result_q   <= '0;
      err_q      <= 1'b0;
      bad_q      <= 1'b0;
      acc_q      <= '0;
      cnt_q      <= '0;
      mReg_q     <= '0;
      xShift_q   <= '0;
      yReg_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid && inReady_q) begin
            mReg_q    <= m;
            xShift_q  <= x;
            yReg_q    <= y;
            acc_q     <= '0;
            cnt_q     <= '0;
            bad_q     <= inputBad;
            inReady_q <= 1'b0;
            state_q   <= inputBad ? FINAL : LOOP;
          end
        end
        LOOP: begin
          acc_q    <= acc_d;
          xShift_q <= xShift_q >> BITS_PER_CYCLE;
          cnt_q    <= cnt_q + CW'(1);
          if (cnt_q == CW'(N - 1)) begin
            state_q <= FINAL;
          end
        end
        FINAL: begin
          outValid_q <= 1'b1;
          if (bad_q) begin
            result_q <= '0;
            err_q    <= 1'b1;
          end else begin
            result_q <= result_d;
            err_q    <= 1'b0;
          end
          state_q <= HOLD;
        end
        HOLD: begin
          if (out_ready) begin
            outValid_q <= 1'b0;
            err_q      <= 1'b0;
            inReady_q  <= 1'b1;
            state_q    <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_montgomery_mult_param.sv
// Testbench for montgomery_mult_param.
// Three 8-bit instances with 1, 2 and 4 bits per cycle run in lockstep on shared operands.
// Expected results come from a plain modular-arithmetic model.
// A negedge monitor pops the expected results and compares them.
// Define MONT_INPUT_CHECK_EN to also cover the input-check path.
module tb_montgomery_mult_param;

  localparam int W = 8;

  typedef struct packed {
    logic [W-1:0] res;
    logic         err;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset;
  logic         inValid;
  logic [W-1:0] mIn, xIn, yIn;
  logic         outReady;
  logic         inReady  [3];
  logic         outValid [3];
  logic [W-1:0] result   [3];
  logic         err      [3];
  logic         prevOv   [3];

  exp_t expQ [3][$];
  int   ks [3] = '{1, 2, 4};
  int   checks = 0;
  int   errors = 0;
  int   cycle = 0;
  int   acceptCyc = 0;
  int   bpMode = 0;

  // Free-running clock
  always #5 clk = ~clk;

  // Cycle counter used for latency measurement
  always @(posedge clk) cycle <= cycle + 1;

  // Consumer back-pressure: 0 always ready, 1 random, 2 stalled
  always @(posedge clk) begin
    #2;
    case (bpMode)
      0: outReady = 1'b1;
      1: outReady = 1'($urandom_range(0, 1));
      default: outReady = 1'b0;
    endcase
  end

  montgomery_mult_param #(.WORD_WIDTH(W), .BITS_PER_CYCLE(1)) dutK1 (
    .clk(clk), .reset(reset), .in_valid(inValid), .in_ready(inReady[0]),
    .m(mIn), .x(xIn), .y(yIn), .out_valid(outValid[0]), .out_ready(outReady),
    .result(result[0]), .err(err[0]));

  montgomery_mult_param #(.WORD_WIDTH(W), .BITS_PER_CYCLE(2)) dutK2 (
    .clk(clk), .reset(reset), .in_valid(inValid), .in_ready(inReady[1]),
    .m(mIn), .x(xIn), .y(yIn), .out_valid(outValid[1]), .out_ready(outReady),
    .result(result[1]), .err(err[1]));

  montgomery_mult_param #(.WORD_WIDTH(W), .BITS_PER_CYCLE(4)) dutK4 (
    .clk(clk), .reset(reset), .in_valid(inValid), .in_ready(inReady[2]),
    .m(mIn), .x(xIn), .y(yIn), .out_valid(outValid[2]), .out_ready(outReady),
    .result(result[2]), .err(err[2]));

  // Reference: x*y*R^-1 mod m with R = 2^W, finding R^-1 by search
  function automatic exp_t refModel(input int mm, input int xx, input int yy);
    exp_t e;
    int   rinv;
    e.err = 1'b0;
    e.res = '0;
`ifdef MONT_INPUT_CHECK_EN
    if ((mm % 2) == 0 || xx >= mm || yy >= mm) begin
      e.err = 1'b1;
      return e;
    end
`endif
    rinv = 0;
    for (int r = 0; r < mm; r++) begin
      if (((r * (1 << W)) % mm) == 1) rinv = r;
    end
    e.res = W'((((xx * yy) % mm) * rinv) % mm);
    return e;
  endfunction

  task automatic checkVal(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("[TB] FAIL %s got %0d want %0d", name, got, want);
    end
  endtask

  task automatic checkOutput(input int i, input exp_t e);
    checkVal($sformatf("k%0d result", ks[i]), int'(result[i]), int'(e.res));
    checkVal($sformatf("k%0d err", ks[i]), int'(err[i]), int'(e.err));
  endtask

  // Monitor: check latency on out_valid rise and pop/compare on each output handshake
  always @(negedge clk) begin
    if (reset) begin
      for (int i = 0; i < 3; i++) prevOv[i] = 1'b0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (outValid[i] && !prevOv[i]) begin
          if (expQ[i].size() == 0) begin
            checkVal($sformatf("k%0d unexpected out_valid", ks[i]), 1, 0);
          end else begin
            checkVal($sformatf("k%0d latency", ks[i]), cycle - acceptCyc,
                     expQ[i][0].err ? 1 : (W / ks[i] + 1));
          end
        end
        if (outValid[i] && outReady) begin
          if (expQ[i].size() == 0) begin
            checkVal($sformatf("k%0d unexpected handshake", ks[i]), 1, 0);
          end else begin
            checkOutput(i, expQ[i].pop_front());
          end
        end
        prevOv[i] = outValid[i];
      end
    end
  end

  // Wait for all instances to be ready, present one operand set, and queue expectations
  task automatic applyStimulus(input int mm, input int xx, input int yy, input bit scramble);
    int   waitCnt = 0;
    exp_t e;
    while (!(inReady[0] && inReady[1] && inReady[2]) && waitCnt < 300) begin
      @(posedge clk); #1;
      waitCnt++;
    end
    if (waitCnt >= 300) begin
      checkVal("accept timeout", 1, 0);
      return;
    end
    mIn = W'(mm); xIn = W'(xx); yIn = W'(yy);
    inValid = 1'b1;
    e = refModel(mm, xx, yy);
    for (int i = 0; i < 3; i++) expQ[i].push_back(e);
    @(posedge clk); #1;
    acceptCyc = cycle;
    inValid = 1'b0;
    if (scramble) begin
      mIn = W'($urandom); xIn = W'($urandom); yIn = W'($urandom);
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((expQ[0].size() + expQ[1].size() + expQ[2].size()) != 0 && n < 1000) begin
      @(posedge clk); #1;
      n++;
    end
    checkVal("drain outstanding", expQ[0].size() + expQ[1].size() + expQ[2].size(), 0);
  endtask

  task automatic checkIdleOutputs(input string tag);
    for (int i = 0; i < 3; i++) begin
      checkVal($sformatf("%s k%0d in_ready", tag, ks[i]), int'(inReady[i]), 1);
      checkVal($sformatf("%s k%0d out_valid", tag, ks[i]), int'(outValid[i]), 0);
      checkVal($sformatf("%s k%0d result", tag, ks[i]), int'(result[i]), 0);
      checkVal($sformatf("%s k%0d err", tag, ks[i]), int'(err[i]), 0);
    end
  endtask

  // Watchdog so the run always ends
  initial begin
    #400000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog");
  end

  // Main stimulus sequence
  initial begin
    exp_t e;
    int   mm, xx, yy, n;
    reset = 1'b1; inValid = 1'b0; mIn = '0; xIn = '0; yIn = '0; outReady = 1'b1;
    #1;
    checkIdleOutputs("reset");
    repeat (3) @(posedge clk);
    #1; reset = 1'b0;

    // Directed vectors including top-of-range and zero operand
    applyStimulus(13, 5, 7, 1'b0);
    applyStimulus(13, 12, 12, 1'b0);
    applyStimulus(255, 254, 254, 1'b0);
    applyStimulus(255, 0, 200, 1'b0);
    applyStimulus(255, 200, 0, 1'b0);
    drain();

    // Back-pressure with input scrambling during LOOP and ignored in_valid pulses
    bpMode = 2;
    e = refModel(13, 5, 7);
    applyStimulus(13, 5, 7, 1'b1);
    n = 0;
    while (!(outValid[0] && outValid[1] && outValid[2]) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    checkVal("bp all valid", int'(outValid[0] && outValid[1] && outValid[2]), 1);
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      for (int i = 0; i < 3; i++) begin
        checkVal($sformatf("bp k%0d result", ks[i]), int'(result[i]), int'(e.res));
        checkVal($sformatf("bp k%0d in_ready", ks[i]), int'(inReady[i]), 0);
        checkVal($sformatf("bp k%0d out_valid", ks[i]), int'(outValid[i]), 1);
      end
      inValid = c[0];
      xIn = W'($urandom); yIn = W'($urandom);
    end
    inValid = 1'b0;
    bpMode = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      checkVal($sformatf("release k%0d out_valid", ks[i]), int'(outValid[i]), 0);
      checkVal($sformatf("release k%0d in_ready", ks[i]), int'(inReady[i]), 1);
    end
    drain();

    // Reset in the middle of an operation
    applyStimulus(13, 5, 7, 1'b0);
    repeat (2) @(posedge clk);
    #1; reset = 1'b1;
    #1;
    checkIdleOutputs("midreset");
    for (int i = 0; i < 3; i++) expQ[i].delete();
    @(posedge clk); #1; reset = 1'b0;
    applyStimulus(13, 5, 7, 1'b0);
    drain();

    // Randomised operations with random consumer back-pressure
    bpMode = 1;
    for (int t = 0; t < 40; t++) begin
      mm = $urandom_range(1, 127) * 2 + 1;
      if (t % 8 == 0) begin
        xx = mm - 1; yy = mm - 1;
      end else begin
        xx = $urandom_range(0, mm - 1); yy = $urandom_range(0, mm - 1);
      end
      applyStimulus(mm, xx, yy, 1'($urandom_range(0, 1)));
    end
    drain();
    bpMode = 0;

`ifdef MONT_INPUT_CHECK_EN
    // Illegal inputs flagged one clock after accept; legal input unaffected
    applyStimulus(12, 5, 7, 1'b0);
    applyStimulus(13, 13, 3, 1'b0);
    applyStimulus(13, 5, 13, 1'b0);
    applyStimulus(13, 5, 7, 1'b0);
    drain();
`endif

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
